dram_port_arbiter: RTL and testbench

//   Shares the single DRAM model port pair (read, write) between the LeNet engines (conv, bias/relu, pool, fc).

---
 rtl/dram_port_arbiter_pkg.sv | 25 ++
 rtl/dram_port_arbiter_rr_arbiter.sv | 58 +++++
 rtl/dram_port_arbiter.sv | 173 +++++++++++++++++
 tb/tb_dram_port_arbiter.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_port_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// dram_port_arbiter_pkg
//   Shared defaults for the DRAM port arbiter: word/address widths, the
//   outstanding-read limit and the requester index assignments used by the
//   LeNet engines when they hook into the read and write sides.
// ----------------------------------------------------------------------------
package dram_port_arbiter_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 18;
    localparam int DEF_NUM_RD     = 4;
    localparam int DEF_NUM_WR     = 2;
    localparam int DEF_MAX_OUT    = 4;

    // Read-side requester slots.
    localparam int RQ_CONV = 0;
    localparam int RQ_BIAS = 1;
    localparam int RQ_POOL = 2;
    localparam int RQ_FC   = 3;

    // Write-side requester slots.
    localparam int WQ_CONV = 0;
    localparam int WQ_POOL = 1;

endpackage

// File: rtl/dram_port_arbiter_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
//   Round-robin arbiter with a registered priority pointer.
//   Ports:
//     clk, srst   clock, synchronous active-high reset (pointer -> 0)
//     req[N]      request vector
//     advance     grant permitted this cycle; when low gnt is 0
//     gnt[N]      one-hot grant (combinational)
//   After granting k, the search starts at (k+1) mod N. Idle cycles and
//   blocked cycles leave the pointer untouched.
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         srst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic          found;
    int            idx;

    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        gnt   = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = 0;
        if (advance) begin
            for (int off = 0; off < N; off++) begin
                idx = (int'(ptr_q) + off) % N;
                if (!found && req[idx]) begin
                    gnt[idx] = 1'b1;
                    found    = 1'b1;
                    ptr_d    = PW'((idx + 1) % N);
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (srst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/dram_port_arbiter.sv
// ----------------------------------------------------------------------------
// dram_port_arbiter
//   Shares one DRAM read port and one DRAM write port between the LeNet
//   engines. Reads and writes arbitrate independently with round-robin.
//   Read responses return in order; a tag FIFO remembers which requester
//   issued each outstanding read so the response is steered back to it.
//   Ports:
//     clk, srst                   clock, synchronous active-high reset
//     rd_req/rd_addr -> rd_gnt    read requests, packed addresses, grant
//     rd_valid, rd_data           steered read response (pass-through)
//     wr_req/wr_addr/wr_data      write requests, packed address/data
//     wr_gnt                      write grant
//     dram_en_rd, dram_addr_rd    registered DRAM read command
//     dram_valid, dram_data_rd    DRAM read response
//     dram_en_wr, dram_addr_wr,
//     dram_data_wr                registered DRAM write command
//     rsp_err                     sticky: response with no outstanding tag
// ----------------------------------------------------------------------------
module dram_port_arbiter
    import dram_port_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_RD     = DEF_NUM_RD,
    parameter int NUM_WR     = DEF_NUM_WR,
    parameter int MAX_OUT    = DEF_MAX_OUT
) (
    input  logic                         clk,
    input  logic                         srst,
    input  logic [NUM_RD-1:0]            rd_req,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_RD-1:0]            rd_gnt,
    output logic [NUM_RD-1:0]            rd_valid,
    output logic [DATA_WIDTH-1:0]        rd_data,
    input  logic [NUM_WR-1:0]            wr_req,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr,
    input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
    output logic [NUM_WR-1:0]            wr_gnt,
    output logic                         dram_en_rd,
    output logic [ADDR_WIDTH-1:0]        dram_addr_rd,
    input  logic                         dram_valid,
    input  logic [DATA_WIDTH-1:0]        dram_data_rd,
    output logic                         dram_en_wr,
    output logic [ADDR_WIDTH-1:0]        dram_addr_wr,
    output logic [DATA_WIDTH-1:0]        dram_data_wr,
    output logic                         rsp_err
);

    localparam int RIW = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
    localparam int WIW = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;
    localparam int PW  = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CW  = $clog2(MAX_OUT + 1);

    // Tag FIFO state.
    logic [RIW-1:0] tag_mem_q [MAX_OUT];
    logic [PW-1:0]  tag_wr_ptr_q, tag_wr_ptr_d;
    logic [PW-1:0]  tag_rd_ptr_q, tag_rd_ptr_d;
    logic [CW-1:0]  tag_cnt_q, tag_cnt_d;
    logic [RIW-1:0] tag_head;
    logic           tag_push, tag_pop;

    logic           rd_can_grant;
    logic [RIW-1:0] rd_gnt_idx;
    logic [WIW-1:0] wr_gnt_idx;

    // Registered DRAM command and error state.
    logic                  dram_en_rd_q, dram_en_rd_d;
    logic [ADDR_WIDTH-1:0] dram_addr_rd_q, dram_addr_rd_d;
    logic                  dram_en_wr_q, dram_en_wr_d;
    logic [ADDR_WIDTH-1:0] dram_addr_wr_q, dram_addr_wr_d;
    logic [DATA_WIDTH-1:0] dram_data_wr_q, dram_data_wr_d;
    logic                  rsp_err_q, rsp_err_d;

    // Full is judged on the registered count, so a pop in the same cycle
    // does not open a slot until the next cycle.
    assign rd_can_grant = (tag_cnt_q < CW'(MAX_OUT));

    rr_arbiter #(.N(NUM_RD)) u_rd_arb (
        .clk     (clk),
        .srst    (srst),
        .req     (rd_req),
        .advance (rd_can_grant),
        .gnt     (rd_gnt)
    );

    rr_arbiter #(.N(NUM_WR)) u_wr_arb (
        .clk     (clk),
        .srst    (srst),
        .req     (wr_req),
        .advance (1'b1),
        .gnt     (wr_gnt)
    );

    always_comb begin
        rd_gnt_idx = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (rd_gnt[i]) rd_gnt_idx = RIW'(i);
        end
        wr_gnt_idx = '0;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_gnt[j]) wr_gnt_idx = WIW'(j);
        end
    end

    assign tag_push = |rd_gnt;
    assign tag_pop  = dram_valid && (tag_cnt_q != '0);
    assign tag_head = tag_mem_q[tag_rd_ptr_q];

    // Response steering: the head tag selects which requester sees valid.
    always_comb begin
        rd_valid = '0;
        if (tag_pop) rd_valid[tag_head] = 1'b1;
    end
    assign rd_data = dram_data_rd;

    always_comb begin
        tag_wr_ptr_d   = tag_push ? tag_wr_ptr_q + 1'b1 : tag_wr_ptr_q;
        tag_rd_ptr_d   = tag_pop  ? tag_rd_ptr_q + 1'b1 : tag_rd_ptr_q;
        tag_cnt_d      = tag_cnt_q + CW'(tag_push) - CW'(tag_pop);
        rsp_err_d      = rsp_err_q | (dram_valid && (tag_cnt_q == '0));

        dram_en_rd_d   = tag_push;
        dram_addr_rd_d = tag_push
                       ? rd_addr[int'(rd_gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH]
                       : dram_addr_rd_q;

        dram_en_wr_d   = |wr_gnt;
        dram_addr_wr_d = (|wr_gnt)
                       ? wr_addr[int'(wr_gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH]
                       : dram_addr_wr_q;
        dram_data_wr_d = (|wr_gnt)
                       ? wr_data[int'(wr_gnt_idx)*DATA_WIDTH +: DATA_WIDTH]
                       : dram_data_wr_q;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            tag_wr_ptr_q   <= '0;
            tag_rd_ptr_q   <= '0;
            tag_cnt_q      <= '0;
            rsp_err_q      <= 1'b0;
            dram_en_rd_q   <= 1'b0;
            dram_addr_rd_q <= '0;
            dram_en_wr_q   <= 1'b0;
            dram_addr_wr_q <= '0;
            dram_data_wr_q <= '0;
        end else begin
            tag_wr_ptr_q   <= tag_wr_ptr_d;
            tag_rd_ptr_q   <= tag_rd_ptr_d;
            tag_cnt_q      <= tag_cnt_d;
            rsp_err_q      <= rsp_err_d;
            dram_en_rd_q   <= dram_en_rd_d;
            dram_addr_rd_q <= dram_addr_rd_d;
            dram_en_wr_q   <= dram_en_wr_d;
            dram_addr_wr_q <= dram_addr_wr_d;
            dram_data_wr_q <= dram_data_wr_d;
        end
    end

    // NOTE: the tag storage is not reset; an entry is only read after it has
    // been written, and the count register alone defines which entries live.
    always_ff @(posedge clk) begin
        if (tag_push) tag_mem_q[tag_wr_ptr_q] <= rd_gnt_idx;
    end

    assign dram_en_rd   = dram_en_rd_q;
    assign dram_addr_rd = dram_addr_rd_q;
    assign dram_en_wr   = dram_en_wr_q;
    assign dram_addr_wr = dram_addr_wr_q;
    assign dram_data_wr = dram_data_wr_q;
    assign rsp_err      = rsp_err_q;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_dram_port_arbiter
//   Directed bench for dram_port_arbiter. Inputs change 1ns after the rising
//   edge; combinational outputs are sampled 1ns later, registered outputs
//   1ns after the following edge.
// ----------------------------------------------------------------------------
module tb_dram_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 18;
    localparam int NR = 4;
    localparam int NW = 2;

    logic            clk;
    logic            srst;
    logic [NR-1:0]   rd_req;
    logic [NR*AW-1:0] rd_addr;
    logic [NR-1:0]   rd_gnt;
    logic [NR-1:0]   rd_valid;
    logic [DW-1:0]   rd_data;
    logic [NW-1:0]   wr_req;
    logic [NW*AW-1:0] wr_addr;
    logic [NW*DW-1:0] wr_data;
    logic [NW-1:0]   wr_gnt;
    logic            dram_en_rd;
    logic [AW-1:0]   dram_addr_rd;
    logic            dram_valid;
    logic [DW-1:0]   dram_data_rd;
    logic            dram_en_wr;
    logic [AW-1:0]   dram_addr_wr;
    logic [DW-1:0]   dram_data_wr;
    logic            rsp_err;

    int n_tests = 0;
    int n_fail  = 0;

    dram_port_arbiter dut (
        .clk          (clk),
        .srst         (srst),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_gnt       (rd_gnt),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .wr_req       (wr_req),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_gnt       (wr_gnt),
        .dram_en_rd   (dram_en_rd),
        .dram_addr_rd (dram_addr_rd),
        .dram_valid   (dram_valid),
        .dram_data_rd (dram_data_rd),
        .dram_en_wr   (dram_en_wr),
        .dram_addr_wr (dram_addr_wr),
        .dram_data_wr (dram_data_wr),
        .rsp_err      (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        srst         = 1'b1;
        rd_req       = '0;
        wr_req       = '0;
        dram_valid   = 1'b0;
        dram_data_rd = '0;
        tick();
        tick();
        srst = 1'b0;
    endtask

    task automatic test_reset();
        rd_addr = '0;
        wr_addr = '0;
        wr_data = '0;
        do_reset();
        #1;
        n_tests++;
        if ({dram_en_rd, dram_en_wr, rsp_err} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 000", {dram_en_rd, dram_en_wr, rsp_err});
        end
        n_tests++;
        if ({dram_addr_rd, dram_addr_wr, dram_data_wr} !== '0) begin
            n_fail++;
            $display("FAIL reset_regs: got rd %h wr %h data %h expected 0", dram_addr_rd, dram_addr_wr, dram_data_wr);
        end
        n_tests++;
        if ({rd_gnt, wr_gnt, rd_valid} !== '0) begin
            n_fail++;
            $display("FAIL reset_idle_out: got %b expected 0", {rd_gnt, wr_gnt, rd_valid});
        end
    endtask

    // Reader 0 at 0x100, DRAM answers two cycles after the command.
    task automatic test_single_read();
        do_reset();
        tick();
        rd_req            = 4'b0001;
        rd_addr[0*AW +: AW] = 18'h00100;
        #1;
        n_tests++;
        if (rd_gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL single_gnt: got %b expected 0001", rd_gnt);
        end
        tick();
        rd_req = '0;
        n_tests++;
        if (dram_en_rd !== 1'b1 || dram_addr_rd !== 18'h00100) begin
            n_fail++;
            $display("FAIL single_issue: got en %b addr %h expected 1 00100", dram_en_rd, dram_addr_rd);
        end
        tick();
        n_tests++;
        if (dram_en_rd !== 1'b0 || dram_addr_rd !== 18'h00100) begin
            n_fail++;
            $display("FAIL single_hold: got en %b addr %h expected 0 00100", dram_en_rd, dram_addr_rd);
        end
        tick();
        dram_valid   = 1'b1;
        dram_data_rd = 32'hDEADBEEF;
        #1;
        n_tests++;
        if (rd_valid !== 4'b0001 || rd_data !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL single_rsp: got valid %b data %h expected 0001 deadbeef", rd_valid, rd_data);
        end
        tick();
        dram_valid = 1'b0;
    endtask

    // All four readers request continuously; the fifth grant waits for the
    // first response, and the cycle carrying that response still grants nothing.
    task automatic test_rr_full();
        logic [3:0] exp_g [8];
        logic [3:0] exp_v [4];
        logic [AW-1:0] exp_a;
        int gi;
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
        exp_v = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        for (int i = 0; i < NR; i++) rd_addr[i*AW +: AW] = AW'(18'h01000 + i);
        tick();
        rd_req = 4'b1111;
        exp_a  = '0;
        for (int c = 0; c < 8; c++) begin
            if (c == 6) begin
                dram_valid   = 1'b1;
                dram_data_rd = 32'h0000600D;
            end
            #1;
            n_tests++;
            if (rd_gnt !== exp_g[c]) begin
                n_fail++;
                $display("FAIL rr_gnt_c%0d: got %b expected %b", c, rd_gnt, exp_g[c]);
            end
            if (c == 6) begin
                n_tests++;
                if (rd_valid !== 4'b0001) begin
                    n_fail++;
                    $display("FAIL full_pop_valid: got %b expected 0001", rd_valid);
                end
            end
            if (c >= 1) begin
                gi = 0;
                for (int k = 0; k < NR; k++) if (exp_g[c-1][k]) gi = k;
                if (exp_g[c-1] != '0) exp_a = AW'(18'h01000 + gi);
                n_tests++;
                if (dram_en_rd !== (exp_g[c-1] != '0) || dram_addr_rd !== exp_a) begin
                    n_fail++;
                    $display("FAIL rr_issue_c%0d: got en %b addr %h expected %b %h",
                             c, dram_en_rd, dram_addr_rd, (exp_g[c-1] != '0), exp_a);
                end
            end
            tick();
            dram_valid = 1'b0;
        end
        rd_req = '0;
        n_tests++;
        if (dram_en_rd !== 1'b1 || dram_addr_rd !== 18'h01000) begin
            n_fail++;
            $display("FAIL rr_issue_last: got en %b addr %h expected 1 01000", dram_en_rd, dram_addr_rd);
        end
        // Outstanding tags are now 1,2,3,0.
        for (int k = 0; k < 4; k++) begin
            dram_valid   = 1'b1;
            dram_data_rd = 32'hA0 + k;
            #1;
            n_tests++;
            if (rd_valid !== exp_v[k] || rd_data !== 32'hA0 + k) begin
                n_fail++;
                $display("FAIL drain_%0d: got valid %b data %h expected %b %h",
                         k, rd_valid, rd_data, exp_v[k], 32'hA0 + k);
            end
            tick();
        end
        dram_valid = 1'b0;
        tick();
        n_tests++;
        if (rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_no_err: got %b expected 0", rsp_err);
        end
    endtask

    // Reads issued by requesters 2, 0, 3 must come back steered in that order.
    task automatic test_read_order();
        logic [3:0]  seq_req [3];
        logic [31:0] seq_dat [3];
        seq_req = '{4'b0100, 4'b0001, 4'b1000};
        seq_dat = '{32'h22222222, 32'h00000000, 32'h33333333};
        do_reset();
        for (int k = 0; k < 3; k++) begin
            rd_req = seq_req[k];
            #1;
            n_tests++;
            if (rd_gnt !== seq_req[k]) begin
                n_fail++;
                $display("FAIL order_gnt_%0d: got %b expected %b", k, rd_gnt, seq_req[k]);
            end
            tick();
        end
        rd_req = '0;
        tick();
        for (int k = 0; k < 3; k++) begin
            dram_valid   = 1'b1;
            dram_data_rd = seq_dat[k];
            #1;
            n_tests++;
            if (rd_valid !== seq_req[k] || rd_data !== seq_dat[k]) begin
                n_fail++;
                $display("FAIL order_rsp_%0d: got valid %b data %h expected %b %h",
                         k, rd_valid, rd_data, seq_req[k], seq_dat[k]);
            end
            tick();
        end
        dram_valid = 1'b0;
    endtask

    // Pointer must survive idle cycles: after granting 0, requesters 0 and 3
    // together must yield 3.
    task automatic test_rr_idle();
        do_reset();
        rd_req = 4'b0001;
        tick();
        rd_req = '0;
        tick();
        tick();
        rd_req = 4'b1001;
        #1;
        n_tests++;
        if (rd_gnt !== 4'b1000) begin
            n_fail++;
            $display("FAIL rr_idle_keep: got %b expected 1000", rd_gnt);
        end
        tick();
        rd_req = 4'b0001;
        #1;
        n_tests++;
        if (rd_gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL rr_idle_next: got %b expected 0001", rd_gnt);
        end
        tick();
        rd_req = '0;
    endtask

    // Two writers plus a concurrent read.
    task automatic test_back_to_back_write();
        do_reset();
        wr_addr[0*AW +: AW] = 18'd5;
        wr_addr[1*AW +: AW] = 18'd9;
        wr_data[0*DW +: DW] = 32'hAAAA_0001;
        wr_data[1*DW +: DW] = 32'hBBBB_0002;
        rd_addr[1*AW +: AW] = 18'h002A0;
        wr_req = 2'b11;
        rd_req = 4'b0010;
        #1;
        n_tests++;
        if (wr_gnt !== 2'b01 || rd_gnt !== 4'b0010) begin
            n_fail++;
            $display("FAIL wr_gnt0: got wr %b rd %b expected 01 0010", wr_gnt, rd_gnt);
        end
        tick();
        wr_req = 2'b10;
        rd_req = '0;
        #1;
        n_tests++;
        if (wr_gnt !== 2'b10) begin
            n_fail++;
            $display("FAIL wr_gnt1: got %b expected 10", wr_gnt);
        end
        n_tests++;
        if (dram_en_wr !== 1'b1 || dram_addr_wr !== 18'd5 || dram_data_wr !== 32'hAAAA_0001) begin
            n_fail++;
            $display("FAIL wr_first: got en %b addr %h data %h expected 1 5 aaaa0001", dram_en_wr, dram_addr_wr, dram_data_wr);
        end
        n_tests++;
        if (dram_en_rd !== 1'b1 || dram_addr_rd !== 18'h002A0) begin
            n_fail++;
            $display("FAIL wr_conc_read: got en %b addr %h expected 1 002a0", dram_en_rd, dram_addr_rd);
        end
        tick();
        wr_req       = '0;
        dram_valid   = 1'b1;
        dram_data_rd = 32'h1234_5678;
        #1;
        n_tests++;
        if (dram_en_wr !== 1'b1 || dram_addr_wr !== 18'd9 || dram_data_wr !== 32'hBBBB_0002) begin
            n_fail++;
            $display("FAIL wr_second: got en %b addr %h data %h expected 1 9 bbbb0002", dram_en_wr, dram_addr_wr, dram_data_wr);
        end
        n_tests++;
        if (rd_valid !== 4'b0010 || rd_data !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL wr_conc_rsp: got valid %b data %h expected 0010 12345678", rd_valid, rd_data);
        end
        tick();
        dram_valid = 1'b0;
        n_tests++;
        if (dram_en_wr !== 1'b0 || dram_addr_wr !== 18'd9) begin
            n_fail++;
            $display("FAIL wr_idle: got en %b addr %h expected 0 9", dram_en_wr, dram_addr_wr);
        end
    endtask

    // Reset with three reads in flight; a stray response afterwards is an error.
    task automatic test_reset_mid_burst();
        do_reset();
        rd_addr[0*AW +: AW] = 18'h00011;
        rd_addr[1*AW +: AW] = 18'h00022;
        rd_addr[2*AW +: AW] = 18'h00033;
        wr_addr[0*AW +: AW] = 18'h00044;
        wr_data[0*DW +: DW] = 32'hCAFE_F00D;
        rd_req = 4'b0111;
        tick();
        tick();
        wr_req = 2'b01;
        tick();
        rd_req = '0;
        wr_req = '0;
        srst   = 1'b1;
        #1;
        n_tests++;
        if (dram_en_rd !== 1'b1 || dram_en_wr !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_active: got rd %b wr %b expected 1 1", dram_en_rd, dram_en_wr);
        end
        tick();
        srst = 1'b0;
        n_tests++;
        if ({dram_en_rd, dram_addr_rd, dram_en_wr, dram_addr_wr, dram_data_wr, rsp_err} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_out: got en_rd %b addr_rd %h en_wr %b addr_wr %h data_wr %h err %b expected all 0",
                     dram_en_rd, dram_addr_rd, dram_en_wr, dram_addr_wr, dram_data_wr, rsp_err);
        end
        tick();
        dram_valid   = 1'b1;
        dram_data_rd = 32'h0BAD_0BAD;
        #1;
        n_tests++;
        if (rd_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL stray_valid: got %b expected 0000", rd_valid);
        end
        tick();
        dram_valid = 1'b0;
        n_tests++;
        if (rsp_err !== 1'b1) begin
            n_fail++;
            $display("FAIL stray_err_set: got %b expected 1", rsp_err);
        end
        tick();
        tick();
        n_tests++;
        if (rsp_err !== 1'b1) begin
            n_fail++;
            $display("FAIL stray_err_sticky: got %b expected 1", rsp_err);
        end
        do_reset();
        #1;
        n_tests++;
        if (rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_cleared: got %b expected 0", rsp_err);
        end
    endtask

    initial begin
        srst         = 1'b1;
        rd_req       = '0;
        rd_addr      = '0;
        wr_req       = '0;
        wr_addr      = '0;
        wr_data      = '0;
        dram_valid   = 1'b0;
        dram_data_rd = '0;
        test_reset();
        test_single_read();
        test_rr_full();
        test_read_order();
        test_rr_idle();
        test_back_to_back_write();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
